// File: rtl/tristate_bus_arbiter.sv
// Round-robin grant of a shared tristate bus with a per-owner hold limit.
// Define TRISTATE_ARB_TURNAROUND_EN to insert one undriven TURN cycle between owners.
module tristate_bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    bus_busy
);

  localparam int unsigned NR = NREQ;
  localparam int unsigned OW = $clog2(NREQ);
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_TURN  = 2'd2;

  logic [1:0]      r_state;
  logic [OW-1:0]   r_last;
  logic [OW-1:0]   r_owner;
  logic [HW-1:0]   r_hold;
  logic [NREQ-1:0] r_gnt;
  logic            r_busy;

  logic            w_any;
  logic [OW-1:0]   w_win;
  logic [OW-1:0]   w_idx;
  logic [NREQ-1:0] w_win_oh;
  logic            w_release;
  logic            w_take;
  logic            w_drop;
  logic [1:0]      w_drop_state;

  // Scan starts just after the last owner, so that owner ends up lowest priority.
  always_comb begin
    w_any = 1'b0;
    w_win = r_last;
    w_idx = '0;
    for (int unsigned k = 1; k <= NR; k++) begin
      w_idx = OW'((32'(r_last) + k) % NR);
      if (!w_any && req[w_idx]) begin
        w_win = w_idx;
        w_any = 1'b1;
      end
    end
    w_win_oh        = '0;
    w_win_oh[w_win] = 1'b1;
  end

  assign w_release = !req[r_owner] || (r_hold == HW'(MAX_HOLD));

  always_comb begin
    w_take       = 1'b0;
    w_drop       = 1'b0;
    w_drop_state = S_IDLE;
    case (r_state)
      S_IDLE: w_take = w_any;
      S_GRANT: begin
        if (w_release) begin
`ifdef TRISTATE_ARB_TURNAROUND_EN
          w_drop       = 1'b1;
          w_drop_state = S_TURN;
`else
          w_take = w_any;
          w_drop = !w_any;
`endif
        end
      end
      S_TURN: begin
        w_take = w_any;
        w_drop = !w_any;
      end
      default: w_drop = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_last  <= OW'(NR - 1);
      r_owner <= '0;
      r_hold  <= '0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
    end else if (w_take) begin
      r_state <= S_GRANT;
      r_last  <= w_win;
      r_owner <= w_win;
      r_hold  <= HW'(1);
      r_gnt   <= w_win_oh;
      r_busy  <= 1'b1;
    end else if (w_drop) begin
      r_state <= w_drop_state;
      r_owner <= '0;
      r_hold  <= '0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
    end else if (r_state == S_GRANT) begin
      r_hold <= r_hold + 1'b1;
    end
  end

  assign gnt      = r_gnt;
  assign owner    = r_owner;
  assign bus_busy = r_busy;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed vector bench for tristate_bus_arbiter (NREQ=4, MAX_HOLD=4); tables follow
// TRISTATE_ARB_TURNAROUND_EN so the same bench covers both builds.
module tb_tristate_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       bus_busy;

  int n_tests = 0;
  int n_fail  = 0;

  tristate_bus_arbiter #(.NREQ(4), .MAX_HOLD(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt      (gnt),
    .owner    (owner),
    .bus_busy (bus_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [3:0] r, input logic [3:0] g, input int n);
    for (int i = 0; i < n; i++) vecs.push_back('{rst, r, g});
  endtask

  function automatic logic [1:0] oh2idx(input logic [3:0] g);
    logic [1:0] ix;
    ix = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) ix = 2'(i);
    return ix;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] eg);
    check({tag, ".gnt"},      32'(gnt),      32'(eg));
    check({tag, ".owner"},    32'(owner),    32'(oh2idx(eg)));
    check({tag, ".bus_busy"}, 32'(bus_busy), 32'(|eg));
  endtask

  always @(negedge clk) begin
    check("inv.onehot0", 32'($onehot0(gnt)), 32'd1);
    check("inv.busy_or", 32'(bus_busy), 32'(|gnt));
    if (!bus_busy) check("inv.owner_idle", 32'(owner), 32'd0);
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;

`ifdef TRISTATE_ARB_TURNAROUND_EN
    add(1, 4'b1111, 4'b0000, 1);
    add(0, 4'b1111, 4'b0001, 4); add(0, 4'b1111, 4'b0000, 1);
    add(0, 4'b1111, 4'b0010, 4); add(0, 4'b1111, 4'b0000, 1);
    add(0, 4'b1111, 4'b0100, 4); add(0, 4'b1111, 4'b0000, 1);
    add(0, 4'b1111, 4'b1000, 4); add(0, 4'b1111, 4'b0000, 1);
    add(0, 4'b1111, 4'b0001, 1); add(0, 4'b0000, 4'b0000, 2);
    add(0, 4'b0001, 4'b0001, 3); add(0, 4'b0000, 4'b0000, 2);
    add(0, 4'b0100, 4'b0100, 4); add(0, 4'b0100, 4'b0000, 1);
    add(0, 4'b0100, 4'b0100, 4); add(0, 4'b0100, 4'b0000, 1);
    add(0, 4'b0100, 4'b0100, 2);
    add(0, 4'b0101, 4'b0100, 2); add(0, 4'b0101, 4'b0000, 1);
    add(0, 4'b0101, 4'b0001, 1); add(0, 4'b0000, 4'b0000, 2);
    add(0, 4'b0011, 4'b0010, 1); add(0, 4'b0001, 4'b0000, 1);
    add(0, 4'b0001, 4'b0001, 1); add(0, 4'b0000, 4'b0000, 2);
`else
    add(1, 4'b1111, 4'b0000, 1);
    add(0, 4'b1111, 4'b0001, 4); add(0, 4'b1111, 4'b0010, 4);
    add(0, 4'b1111, 4'b0100, 4); add(0, 4'b1111, 4'b1000, 4);
    add(0, 4'b1111, 4'b0001, 1); add(0, 4'b0000, 4'b0000, 2);
    add(0, 4'b0001, 4'b0001, 3); add(0, 4'b0000, 4'b0000, 2);
    add(0, 4'b0100, 4'b0100, 12);
    add(0, 4'b0101, 4'b0001, 1); add(0, 4'b0000, 4'b0000, 2);
    add(1, 4'b0011, 4'b0000, 1);
    add(0, 4'b0011, 4'b0001, 4); add(0, 4'b0011, 4'b0010, 4);
    add(0, 4'b0000, 4'b0000, 1);
`endif

    foreach (vecs[i]) begin
      rst_n = !vecs[i].rst;
      req   = vecs[i].req;
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].gnt);
    end

    // Asynchronous reset while requester 2 owns the bus.
    rst_n = 1'b1;
    req   = 4'b0100;
    @(posedge clk);
    #1;
    check_outs("areset.pre", 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("areset.async", 4'b0000);
    @(posedge clk);
    #1;
    check_outs("areset.held", 4'b0000);
    rst_n = 1'b1;
    req   = 4'b0001;
    @(posedge clk);
    #1;
    check_outs("areset.resume", 4'b0001);
    req = 4'b0000;
    @(posedge clk);
    #1;
    check_outs("areset.release", 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
